// File: rtl/snap2_rst_sequencer_if.sv
// Sequencer bundle: MMCM lock and IDELAYCTRL ready in; IDELAYCTRL/user resets and status out.
interface snap2_rst_sequencer_if;
  logic       pll_lock;
  logic       idelay_rdy;
  logic       idelayctrl_rst;
  logic       user_rst;
  logic       seq_done;
  logic       fault;
  logic [3:0] retry_count;

  modport master (
    output pll_lock, idelay_rdy,
    input  idelayctrl_rst, user_rst, seq_done, fault, retry_count
  );

  modport slave (
    input  pll_lock, idelay_rdy,
    output idelayctrl_rst, user_rst, seq_done, fault, retry_count
  );
endinterface

// File: rtl/snap2_rst_sequencer.sv
// SNAP2 power-up reset sequencer: MMCM lock qualify, IDELAYCTRL reset/ready with retries, user reset.
// Define RST_SEQ_IDELAY_EN to build the IDELAYCTRL stage; without it LOCK_STABLE goes straight to USER_RST.
module snap2_rst_sequencer #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned IDLY_RST_CYCLES    = 16,
  parameter int unsigned RDY_TIMEOUT        = 4096,
  parameter int unsigned MAX_RETRIES        = 3,
  parameter int unsigned USER_RST_CYCLES    = 65535
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  snap2_rst_sequencer_if.slave  bus
);

  localparam logic [15:0] LOCK_LAST = 16'(LOCK_STABLE_CYCLES - 1);
  localparam logic [15:0] USER_LAST = 16'(USER_RST_CYCLES - 1);

`ifdef RST_SEQ_IDELAY_EN
  localparam logic [15:0] IDLY_LAST = 16'(IDLY_RST_CYCLES - 1);
  localparam logic [15:0] RDY_LAST  = 16'(RDY_TIMEOUT - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_WAIT_LOCK, S_LOCK_STABLE, S_IDLY_RST, S_IDLY_WAIT, S_USER_RST, S_RUN, S_FAULT
  } state_e;
`else
  typedef enum logic [2:0] {
    S_WAIT_LOCK, S_LOCK_STABLE, S_USER_RST, S_RUN
  } state_e;
`endif

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        timed;
  logic        user_rst_q, seq_done_q;

  logic lock_meta_q, lock_s_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= bus.pll_lock;
      lock_s_q    <= lock_meta_q;
    end
  end

`ifdef RST_SEQ_IDELAY_EN
  logic       rdy_meta_q, rdy_s_q;
  logic [3:0] retry_q, retry_d;
  logic       idly_rst_q, fault_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rdy_meta_q <= 1'b0;
      rdy_s_q    <= 1'b0;
    end else begin
      rdy_meta_q <= bus.idelay_rdy;
      rdy_s_q    <= rdy_meta_q;
    end
  end
`else
  logic unused_idelay_rdy;
  assign unused_idelay_rdy = bus.idelay_rdy;
`endif

  always_comb begin
    state_d = state_q;
    timed   = 1'b0;
`ifdef RST_SEQ_IDELAY_EN
    retry_d = retry_q;
`endif
    unique case (state_q)
      S_WAIT_LOCK: begin
        if (lock_s_q) state_d = S_LOCK_STABLE;
      end
      S_LOCK_STABLE: begin
        timed = 1'b1;
`ifdef RST_SEQ_IDELAY_EN
        if (cnt_q == LOCK_LAST) state_d = S_IDLY_RST;
`else
        if (cnt_q == LOCK_LAST) state_d = S_USER_RST;
`endif
      end
`ifdef RST_SEQ_IDELAY_EN
      S_IDLY_RST: begin
        timed = 1'b1;
        if (cnt_q == IDLY_LAST) state_d = S_IDLY_WAIT;
      end
      S_IDLY_WAIT: begin
        timed = 1'b1;
        if (rdy_s_q) begin
          state_d = S_USER_RST;
        end else if (cnt_q == RDY_LAST) begin
          retry_d = retry_q + 4'd1;
          state_d = (retry_d == RETRY_MAX) ? S_FAULT : S_IDLY_RST;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
`endif
      S_USER_RST: begin
        timed = 1'b1;
        if (cnt_q == USER_LAST) state_d = S_RUN;
      end
      S_RUN: begin
`ifdef RST_SEQ_IDELAY_EN
        if (!rdy_s_q) state_d = S_IDLY_RST;
`endif
      end
      default: state_d = S_WAIT_LOCK;
    endcase

    // Lock loss overrides everything, including a retry increment decided above.
    if (state_q != S_WAIT_LOCK && !lock_s_q) begin
      state_d = S_WAIT_LOCK;
`ifdef RST_SEQ_IDELAY_EN
      retry_d = retry_q;
`endif
    end

`ifdef RST_SEQ_IDELAY_EN
    if (state_d == S_LOCK_STABLE && state_q != S_LOCK_STABLE) retry_d = '0;
`endif

    if (state_d != state_q) cnt_d = '0;
    else if (timed)         cnt_d = cnt_q + 16'd1;
    else                    cnt_d = cnt_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_WAIT_LOCK;
      cnt_q      <= '0;
      user_rst_q <= 1'b1;
      seq_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      user_rst_q <= (state_d != S_RUN);
      seq_done_q <= (state_d == S_RUN);
    end
  end

`ifdef RST_SEQ_IDELAY_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      retry_q    <= '0;
      idly_rst_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      retry_q    <= retry_d;
      idly_rst_q <= (state_d == S_IDLY_RST);
      fault_q    <= (state_d == S_FAULT);
    end
  end

  assign bus.idelayctrl_rst = idly_rst_q;
  assign bus.fault          = fault_q;
  assign bus.retry_count    = retry_q;
`else
  assign bus.idelayctrl_rst = 1'b0;
  assign bus.fault          = 1'b0;
  assign bus.retry_count    = '0;
`endif

  assign bus.user_rst = user_rst_q;
  assign bus.seq_done = seq_done_q;

endmodule
